pe_residual_sequencer: RTL and testbench

- Parametrised successor of the single-pass PE controller for residual-binarised layers.
- Sequences NUM_LEVELS residual levels × NUM_CHUNKS input-memory words through the read → popcount → accumulate datapath, then one binarize phase.
- Chunk, level and popcount-latency counters are internal, replacing the external cntDone/readDone/pcntDone strobes.
- Adds a memory-read handshake with timeout, an abort input and a sticky error state.

---
 rtl/pe_residual_sequencer.sv | 103 ++++++++++
 tb/tb_pe_residual_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pe_residual_sequencer.sv
// pe_residual_sequencer: read/popcount/accumulate sequencer over residual levels and chunks, then one binarize phase
module pe_residual_sequencer #(
  parameter int NUM_LEVELS = 2,
  parameter int NUM_CHUNKS = 4,
  parameter int PCNT_LAT   = 2,
  parameter int ADDR_W     = 8,
  parameter int LVL_W      = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_mem_rd_req,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic              i_mem_rd_valid,
  output logic              o_pcnt_en,
  output logic              o_acc_en,
  output logic              o_acc_clr,
  output logic [LVL_W-1:0]  o_level_idx,
  output logic              o_bin_start,
  input  logic              i_bin_done,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int CW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  localparam int PW = $clog2(PCNT_LAT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_READ, S_WAIT, S_PCNT, S_ACC, S_BIN, S_BWAIT, S_DONE, S_ERR
  } state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_chunk;
  logic [LVL_W-1:0]  r_level;
  logic [ADDR_W-1:0] r_addr;
  logic [PW-1:0]     r_lat;
  logic [TW-1:0]     r_to;
  logic              w_last_chunk, w_last_level, w_lat_done, w_to_done;
  assign w_last_chunk = r_chunk == CW'(NUM_CHUNKS - 1);
  assign w_last_level = r_level == LVL_W'(NUM_LEVELS - 1);
  assign w_lat_done   = r_lat == PW'(PCNT_LAT - 1);
  assign w_to_done    = r_to == TW'(TIMEOUT - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_CLEAR : S_IDLE;
      S_CLEAR: w_next = S_READ;
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = i_mem_rd_valid ? S_PCNT : (w_to_done ? S_ERR : S_WAIT);
      S_PCNT:  w_next = w_lat_done ? S_ACC : S_PCNT;
      S_ACC:   w_next = (w_last_chunk && w_last_level) ? S_BIN : S_READ;
      S_BIN:   w_next = S_BWAIT;
      S_BWAIT: w_next = i_bin_done ? S_DONE : S_BWAIT;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end
  // the address tracks level*NUM_CHUNKS+chunk, so it simply steps by one per ACC
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_chunk <= '0;
      r_level <= '0;
      r_addr  <= '0;
      r_lat   <= '0;
      r_to    <= '0;
    end else begin
      r_state <= w_next;
      if (i_abort || r_state == S_CLEAR || r_state == S_DONE) begin
        r_chunk <= '0;
        r_level <= '0;
        r_addr  <= '0;
        r_lat   <= '0;
        r_to    <= '0;
      end else begin
        if (r_state == S_READ) r_to <= '0;
        if (r_state == S_WAIT) begin
          if (i_mem_rd_valid) r_lat <= '0;
          else r_to <= r_to + 1'b1;
        end
        if (r_state == S_PCNT) r_lat <= r_lat + 1'b1;
        if (r_state == S_ACC && !(w_last_chunk && w_last_level)) begin
          r_chunk <= w_last_chunk ? '0 : r_chunk + 1'b1;
          r_level <= w_last_chunk ? r_level + 1'b1 : r_level;
          r_addr  <= r_addr + 1'b1;
        end
      end
    end
  end
  assign o_mem_rd_req  = r_state == S_READ;
  assign o_mem_rd_addr = r_addr;
  assign o_level_idx   = r_level;
  assign o_pcnt_en     = r_state == S_PCNT;
  assign o_acc_en      = r_state == S_ACC;
  assign o_acc_clr     = r_state == S_CLEAR;
  assign o_bin_start   = r_state == S_BIN;
  assign o_done        = r_state == S_DONE;
  assign o_err         = r_state == S_ERR;
  assign o_busy        = !(r_state == S_IDLE || r_state == S_ERR);
endmodule

// File: tb/tb_pe_residual_sequencer.sv
// tb_pe_residual_sequencer: per-cycle expected-output tables built from transaction descriptions, two parameter sets
module tb_pe_residual_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0, sel = 1'b0;
  logic start = 1'b0, abort = 1'b0, valid = 1'b0, bdone = 1'b0;
  logic a_req, a_pcnt, a_acc, a_clr, a_bst, a_busy, a_done, a_err, b_req, b_pcnt, b_acc, b_clr, b_bst, b_busy, b_done, b_err;
  logic [7:0] a_addr, b_addr;
  logic [0:0] a_lvl, b_lvl;
  logic [16:0] got;
  pe_residual_sequencer #(.NUM_LEVELS(2), .NUM_CHUNKS(3), .PCNT_LAT(2), .ADDR_W(8), .LVL_W(1), .TIMEOUT(8)) u_a (
    .clk(clk), .rst(rst), .i_start(start & ~sel), .i_abort(abort & ~sel),
    .o_mem_rd_req(a_req), .o_mem_rd_addr(a_addr), .i_mem_rd_valid(valid & ~sel),
    .o_pcnt_en(a_pcnt), .o_acc_en(a_acc), .o_acc_clr(a_clr), .o_level_idx(a_lvl),
    .o_bin_start(a_bst), .i_bin_done(bdone & ~sel), .o_busy(a_busy), .o_done(a_done), .o_err(a_err));
  pe_residual_sequencer #(.NUM_LEVELS(1), .NUM_CHUNKS(1), .PCNT_LAT(1), .ADDR_W(8), .LVL_W(1), .TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .i_start(start & sel), .i_abort(abort & sel),
    .o_mem_rd_req(b_req), .o_mem_rd_addr(b_addr), .i_mem_rd_valid(valid & sel),
    .o_pcnt_en(b_pcnt), .o_acc_en(b_acc), .o_acc_clr(b_clr), .o_level_idx(b_lvl),
    .o_bin_start(b_bst), .i_bin_done(bdone & sel), .o_busy(b_busy), .o_done(b_done), .o_err(b_err));
  assign got = sel ? {b_req, b_pcnt, b_acc, b_clr, b_bst, b_busy, b_done, b_err, b_addr, b_lvl}
                   : {a_req, a_pcnt, a_acc, a_clr, a_bst, a_busy, a_done, a_err, a_addr, a_lvl};
  typedef struct {
    logic start, abort, valid, bdone;
    logic req, pcnt, acc, clr, bst, busy, done, err, ac;
    logic [7:0] addr;
    logic lvl;
  } vec_t;
  vec_t q[$];
  int dq[$];
  int n_chk = 0, n_pass = 0;
  int cL, cC, cP, cTO;
  int t_clr, t_done, n_req, n_acc, n_bst, n_done;
  bit noise = 1'b0;
  string ph = "reset";
  function automatic vec_t mk(input bit req, pcnt, acc, clr, bst, busy, done, err, input int addr, lvl, input bit ac);
    vec_t v;
    v = '{1'b0, 1'b0, 1'b0, 1'b0, req, pcnt, acc, clr, bst, busy, done, err, ac, 8'(addr), 1'(lvl)};
    return v;
  endfunction
  function automatic logic nz();
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [16:0] g, e, m);
    n_chk++;
    if ((g & m) === (e & m)) n_pass++;
    else $display("FAIL %s/%s step %0d: got %h expected %h (mask %h)", ph, nm, idx, g, e, m);
  endtask
  task automatic chk_int(input string nm, input int g, e);
    n_chk++;
    if (g == e) n_pass++;
    else $display("FAIL %s/%s: got %0d expected %0d", ph, nm, g, e);
  endtask
  task automatic fill(input int n, v);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(v);
  endtask
  // one layer pass: dq[k] = WAIT cycles for read k (beyond cTO means timeout), bd = BIN-wait cycles, ab = abort step
  task automatic gen_run(input int bd, ab);
    int base, k;
    bit stop;
    vec_t v;
    base = q.size();
    stop = 1'b0;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); v.start = 1'b1; q.push_back(v);
    v = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1); v.start = nz(); v.valid = nz(); q.push_back(v);
    for (int l = 0; l < cL && !stop; l++)
      for (int c = 0; c < cC && !stop; c++) begin
        k = l * cC + c;
        v = mk(1, 0, 0, 0, 0, 1, 0, 0, k, l, 1); v.start = nz(); v.valid = nz(); q.push_back(v);
        for (int w = 1; w <= dq[k] && w <= cTO; w++) begin
          v = mk(0, 0, 0, 0, 0, 1, 0, 0, k, l, 1); v.start = nz(); v.valid = (w == dq[k]); q.push_back(v);
        end
        if (dq[k] > cTO) begin
          for (int i = 0; i < 3; i++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); v.start = (i < 2); v.valid = nz(); v.abort = (i == 2); q.push_back(v);
          end
          q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
          stop = 1'b1;
        end else begin
          for (int p = 0; p < cP; p++) begin
            v = mk(0, 1, 0, 0, 0, 1, 0, 0, k, l, 1); v.start = nz(); v.valid = nz(); q.push_back(v);
          end
          v = mk(0, 0, 1, 0, 0, 1, 0, 0, k, l, 1); v.start = nz(); v.valid = nz(); q.push_back(v);
        end
      end
    if (!stop) begin
      k = cL * cC - 1;
      v = mk(0, 0, 0, 0, 1, 1, 0, 0, k, cL - 1, 1); v.start = nz(); v.bdone = nz(); q.push_back(v);
      for (int b = 1; b <= bd; b++) begin
        v = mk(0, 0, 0, 0, 0, 1, 0, 0, k, cL - 1, 1); v.start = nz(); v.bdone = (b == bd); q.push_back(v);
      end
      v = mk(0, 0, 0, 0, 0, 1, 1, 0, k, cL - 1, 1); v.valid = nz(); q.push_back(v);
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    if (ab >= 0 && base + ab < q.size() - 1) begin
      while (q.size() > base + ab + 1) void'(q.pop_back());
      q[base + ab].abort = 1'b1;
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
  endtask
  task automatic apply();
    logic [16:0] e, m;
    t_clr = -1; t_done = -1; n_req = 0; n_acc = 0; n_bst = 0; n_done = 0;
    foreach (q[i]) begin
      @(negedge clk);
      start = q[i].start; abort = q[i].abort; valid = q[i].valid; bdone = q[i].bdone;
      e = {q[i].req, q[i].pcnt, q[i].acc, q[i].clr, q[i].bst, q[i].busy, q[i].done, q[i].err, q[i].addr, q[i].lvl};
      m = q[i].ac ? 17'h1FFFF : {8'hFF, 9'h0};
      chk("outputs", i, got, e, m);
      if (got[13] && t_clr < 0) t_clr = i;
      if (got[10] && t_done < 0) t_done = i;
      n_req += int'(got[16]); n_acc += int'(got[14]); n_bst += int'(got[12]); n_done += int'(got[10]);
    end
    q.delete();
  endtask
  task automatic cfg(input bit s);
    sel = s;
    if (!s) begin cL = 2; cC = 3; cP = 2; cTO = 8; end
    else begin cL = 1; cC = 1; cP = 1; cTO = 4; end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat0;
    cfg(0);
    rst = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_a", i, got, 17'h0, 17'h1FFFF);
    end
    sel = 1'b1;
    @(negedge clk);
    chk("rst_b", 0, got, 17'h0, 17'h1FFFF);
    sel = 1'b0; start = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_after_rst", i, got, 17'h0, 17'h1FFFF);
    end
    ph = "nominal";
    lat0 = 1 + cL * cC * (cP + 3) + 2;
    fill(6, 1); gen_run(1, -1); apply();
    chk_int("latency", t_done - t_clr, lat0);
    chk_int("req_pulses", n_req, 6);
    chk_int("acc_pulses", n_acc, 6);
    chk_int("bin_start_pulses", n_bst, 1);
    ph = "stall";
    fill(6, 1); dq[1] = 5; gen_run(1, -1); apply();
    chk_int("latency", t_done - t_clr, lat0 + 4);
    ph = "abort_pcnt";
    fill(6, 1); gen_run(1, 19); apply();
    chk_int("no_done", n_done, 0);
    ph = "restart";
    fill(6, 1); gen_run(2, -1); apply();
    chk_int("done_pulses", n_done, 1);
    cfg(1);
    ph = "timeout";
    fill(1, 100); gen_run(1, -1); apply();
    chk_int("no_done", n_done, 0);
    ph = "degenerate";
    fill(1, 1); gen_run(2, -1);
    foreach (q[i]) if (q[i].bst || (q[i].busy && !q[i].req && !q[i].pcnt && !q[i].acc && !q[i].clr && !q[i].done)) q[i].start = 1'b1;
    apply();
    chk_int("req_pulses", n_req, 1);
    chk_int("acc_pulses", n_acc, 1);
    chk_int("bin_start_pulses", n_bst, 1);
    chk_int("done_pulses", n_done, 1);
    ph = "random";
    noise = 1'b1;
    for (int r = 0; r < 60; r++) begin
      int bd, ab;
      cfg(1'($urandom_range(0, 1)));
      dq.delete();
      for (int k = 0; k < cL * cC; k++)
        dq.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, cTO + 2)) : int'($urandom_range(1, 3)));
      bd = int'($urandom_range(1, 3));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      gen_run(bd, ab);
      apply();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
